aes_v2_iter: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle AES v2 SubBytes/MixColumn instruction unit.
- Trades latency for area by iterating over the four byte lanes with a configurable number of S-box and mix-column lanes per cycle.
- Sits in the CPU execute stage behind a valid/ready handshake.
- Supports early abort when valid drops (pipeline flush).

---
 rtl/aes_v2_iter.sv | 175 +++++++++++++++++
 tb/tb_aes_v2_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_v2_iter.sv
// Multi-cycle AES SubBytes / MixColumn instruction unit: iterates over the four byte lanes
// using SBOX_COUNT S-boxes or MIX_LANES mix-column lanes per cycle.
module aes_v2_iter #(
    parameter int unsigned DECRYPT_EN = 1,
    parameter int unsigned SBOX_COUNT = 4,
    parameter int unsigned MIX_LANES  = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic        sub,
    input  logic        enc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        ready,
    output logic [31:0] rd
);

    if (SBOX_COUNT != 1 && SBOX_COUNT != 2 && SBOX_COUNT != 4) begin : g_bad_sbox_count
        $error("aes_v2_iter: SBOX_COUNT must be 1, 2 or 4");
    end
    if (MIX_LANES != 1 && MIX_LANES != 2 && MIX_LANES != 4) begin : g_bad_mix_lanes
        $error("aes_v2_iter: MIX_LANES must be 1, 2 or 4");
    end

    localparam logic [1:0] SboxLast = 2'(4 / SBOX_COUNT - 1);
    localparam logic [1:0] MixLast  = 2'(4 / MIX_LANES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [1:0]  step_q;
    logic        ready_q;
    logic [31:0] rd_q;
    logic [31:0] op_q;
    logic        sub_q;
    logic        enc_q;

    logic [31:0] op_cap;
    logic [31:0] res_d;
    logic [1:0]  lane;
    logic [1:0]  last_step;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse computed as a^254, which conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic e);
        if (!e && DECRYPT_EN != 0) return inv_sbox(b);
        return fwd_sbox(b);
    endfunction

    function automatic logic [7:0] mix_byte(input logic [31:0] w, input logic [1:0] j,
                                            input logic e);
        logic [1:0] j1, j2, j3;
        logic [7:0] b0, b1, b2, b3;
        j1 = j + 2'd1;
        j2 = j + 2'd2;
        j3 = j + 2'd3;
        b0 = w[8*j +: 8];
        b1 = w[8*j1 +: 8];
        b2 = w[8*j2 +: 8];
        b3 = w[8*j3 +: 8];
        if (e) return xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        if (DECRYPT_EN != 0) begin
            return gf_mul(b0, 8'h0e) ^ gf_mul(b1, 8'h0b) ^ gf_mul(b2, 8'h0d) ^ gf_mul(b3, 8'h09);
        end
        return 8'h00;
    endfunction

    assign op_cap = sub ? {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]}
                        : {rs2[31:16], rs1[15:0]};

    assign last_step = sub_q ? SboxLast : MixLast;

    // Lane mux: the same P datapath copies are steered onto lanes step*P .. step*P+P-1.
    always_comb begin
        res_d = rd_q;
        lane  = 2'd0;
        if (sub_q) begin
            for (int unsigned k = 0; k < SBOX_COUNT; k++) begin
                lane = 2'(32'(step_q) * SBOX_COUNT + k);
                res_d[8*lane +: 8] = sub_byte(op_q[8*lane +: 8], enc_q);
            end
        end else begin
            for (int unsigned k = 0; k < MIX_LANES; k++) begin
                lane = 2'(32'(step_q) * MIX_LANES + k);
                res_d[8*lane +: 8] = mix_byte(op_q, lane, enc_q);
            end
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            ready_q <= 1'b0;
            rd_q    <= 32'h0;
            op_q    <= 32'h0;
            sub_q   <= 1'b0;
            enc_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid) begin
                        op_q    <= op_cap;
                        sub_q   <= sub;
                        enc_q   <= enc;
                        step_q  <= 2'd0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!valid) begin
                        state_q <= StIdle;
                        step_q  <= 2'd0;
                    end else begin
                        rd_q <= res_d;
                        if (step_q == last_step) begin
                            state_q <= StDone;
                            step_q  <= 2'd0;
                        end else begin
                            step_q <= step_q + 2'd1;
                        end
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready = ready_q;
    assign rd    = rd_q;

endmodule

// File: tb/tb_aes_v2_iter.sv
// Scoreboard bench for aes_v2_iter: three configurations run concurrently against a
// table-driven AES reference model.
module tb_aes_v2_iter;

    localparam int NI = 3;
    localparam int unsigned DEC [NI] = '{1, 1, 0};
    localparam int unsigned SBC [NI] = '{4, 1, 2};
    localparam int unsigned MLN [NI] = '{4, 2, 1};

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    logic        rst   [NI];
    logic        valid [NI];
    logic        sub   [NI];
    logic        enc   [NI];
    logic [31:0] rs1   [NI];
    logic [31:0] rs2   [NI];
    logic        ready [NI];
    logic [31:0] rd    [NI];

    exp_t        exp_q [NI][$];
    logic [7:0]  sbox_t [256];
    logic [7:0]  inv_t  [256];
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_v2_iter #(.DECRYPT_EN(1), .SBOX_COUNT(4), .MIX_LANES(4)) u_dut0 (
        .g_clk(clk), .g_reset(rst[0]), .valid(valid[0]), .sub(sub[0]), .enc(enc[0]),
        .rs1(rs1[0]), .rs2(rs2[0]), .ready(ready[0]), .rd(rd[0])
    );
    aes_v2_iter #(.DECRYPT_EN(1), .SBOX_COUNT(1), .MIX_LANES(2)) u_dut1 (
        .g_clk(clk), .g_reset(rst[1]), .valid(valid[1]), .sub(sub[1]), .enc(enc[1]),
        .rs1(rs1[1]), .rs2(rs2[1]), .ready(ready[1]), .rd(rd[1])
    );
    aes_v2_iter #(.DECRYPT_EN(0), .SBOX_COUNT(2), .MIX_LANES(1)) u_dut2 (
        .g_clk(clk), .g_reset(rst[2]), .valid(valid[2]), .sub(sub[2]), .enc(enc[2]),
        .rs1(rs1[2]), .rs2(rs2[2]), .ready(ready[2]), .rd(rd[2])
    );

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s dut%0d @cyc %0d: got %h, want %h", name, i, cyc, act, want);
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = 16'h0;
        for (int k = 0; k < 8; k++) if (y[k]) p ^= {8'h00, x} << k;
        for (int k = 15; k >= 8; k--) if (p[k]) p ^= 16'h011b << (k - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] model(input int i, input bit s, input bit e,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  v  [4];
        logic [7:0]  cf [4];
        logic [7:0]  y;
        logic [31:0] r;
        v[3] = b[31:24];
        v[2] = s ? a[23:16] : b[23:16];
        v[1] = s ? b[15:8] : a[15:8];
        v[0] = a[7:0];
        if (e) begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end else begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end
        r = 32'h0;
        for (int j = 0; j < 4; j++) begin
            y = 8'h00;
            if (s) y = (!e && DEC[i] != 0) ? inv_t[v[j]] : sbox_t[v[j]];
            else if (e || DEC[i] != 0)
                for (int k = 0; k < 4; k++) y ^= gmul(cf[k], v[(j + k) % 4]);
            r[8*j +: 8] = y;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (ready[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    check("spurious_ready", i, {31'd0, ready[i]}, 32'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    check("rd", i, rd[i], e.res);
                    check("latency", i, 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // sync=0 drives on the current negedge (right after a ready); keep=1 leaves valid high.
    task automatic do_op(input int i, input bit s, input bit e, input logic [31:0] a,
                         input logic [31:0] b, input bit sync, input bit keep);
        exp_t x;
        bit   got;
        int   n;
        if (sync) @(negedge clk);
        sub[i] = s; enc[i] = e; rs1[i] = a; rs2[i] = b; valid[i] = 1'b1;
        n = 4 / int'(s ? SBC[i] : MLN[i]);
        x.res = model(i, s, e, a, b);
        x.due = cyc + n + 2;
        exp_q[i].push_back(x);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = ready[i];
        end
        if (!got) begin
            check("ready_timeout", i, {31'd0, got}, 32'd1);
            exp_q[i].delete();
        end
        if (!keep) valid[i] = 1'b0;
    endtask

    task automatic do_abort(input int i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sub[i] = 1'b1; enc[i] = 1'b1; rs1[i] = a; rs2[i] = b; valid[i] = 1'b1;
        repeat ((SBC[i] == 4) ? 1 : 2) @(negedge clk);
        valid[i] = 1'b0;
        rs1[i] = ~a; rs2[i] = ~b;
    endtask

    task automatic do_reset_mid(input int i);
        @(negedge clk);
        sub[i] = 1'b1; enc[i] = 1'b1; rs1[i] = $urandom; rs2[i] = $urandom; valid[i] = 1'b1;
        @(posedge clk);
        #2 rst[i] = 1'b1;
        #1;
        check("async_reset_ready", i, {31'd0, ready[i]}, 32'd0);
        check("async_reset_rd", i, rd[i], 32'd0);
        @(negedge clk);
        valid[i] = 1'b0;
        rst[i]   = 1'b0;
    endtask

    task automatic run_inst(input int i);
        @(negedge clk);
        check("reset_ready", i, {31'd0, ready[i]}, 32'd0);
        check("reset_rd", i, rd[i], 32'd0);
        rst[i] = 1'b0;
        do_op(i, 1'b1, 1'b1, 32'h00530000, 32'h53000000, 1'b1, 1'b0);
        do_op(i, 1'b1, 1'b0, 32'h00ED0063, 32'h63004500, 1'b1, 1'b0);
        do_op(i, 1'b0, 1'b1, 32'h000013DB, 32'h45530000, 1'b1, 1'b0);
        do_op(i, 1'b0, 1'b0, 32'h00004D8E, 32'hBCA10000, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++)
            do_op(i, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        do_abort(i, $urandom, $urandom);
        do_op(i, 1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
        do_op(i, 1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b1);
        do_op(i, 1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
        do_reset_mid(i);
        do_op(i, 1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
    endtask

    initial begin
        logic [7:0] iv;
        logic [7:0] s;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; sub[i] = 1'b0; enc[i] = 1'b0;
            rs1[i] = 32'h0; rs2[i] = 32'h0;
        end
        // S-box tables built from field inverses found by exhaustive search.
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            s = 8'h63;
            for (int k = 0; k < 5; k++) s ^= rotl8(iv, k);
            sbox_t[x] = s;
            inv_t[s]  = 8'(x);
        end
        fork
            run_inst(0);
            run_inst(1);
            run_inst(2);
        join
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
